amp_gain_spi_slave: RTL and testbench

Synthesizable, clock-sampled SPI slave for a programmable-gain amplifier bank, generalised from the fixed two-channel, 4-bit LTC6912-1 model. It holds `CHANNELS` gain codes of `GAIN_W` bits and commits them atomically on a correctly sized, in-range frame. It flags frame-length and code-range errors and echoes the previous register contents on `AMP_DOUT` for daisy-chain readback. It sits in the ADC front-end, driven by the same SPI master as the ADC, and its `GAIN` bus feeds range-aware post-processing.

---
 rtl/amp_pkg.sv | 19 +
 rtl/amp_gain_spi_slave_sync_edge.sv | 34 +++
 rtl/amp_gain_spi_slave.sv | 153 +++++++++++++++
 tb/tb_amp_gain_spi_slave.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/amp_pkg.sv
// Shared types and sizing helpers for the programmable-gain amplifier SPI slave.
package amp_pkg;

  typedef enum logic [1:0] {
    ST_SHUTDOWN = 2'd0,
    ST_IDLE     = 2'd1,
    ST_SHIFT    = 2'd2
  } amp_state_e;

  function automatic int frame_bits(input int ch, input int w);
    return ch * w;
  endfunction

  // Counter must hold FRAME+1 so that an over-length frame stays distinguishable.
  function automatic int cnt_bits(input int frame);
    return $clog2(frame + 2);
  endfunction

endpackage

// File: rtl/amp_gain_spi_slave_sync_edge.sv
// Two-flop synchroniser with registered edge pulses; level and pulses change on the same clock.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_reg;
  logic       prev_reg;
  logic       rise_reg;
  logic       fall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], async_in};
      prev_reg <= sync_reg[1];
      rise_reg <= sync_reg[1] & ~prev_reg;
      fall_reg <= ~sync_reg[1] & prev_reg;
    end
  end

  assign level = prev_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/amp_gain_spi_slave.sv
// Clock-sampled SPI slave holding CHANNELS gain codes; commits atomically on a full, in-range frame.
module amp_gain_spi_slave
  import amp_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int GAIN_W   = 4,
  parameter int MAX_CODE = 7
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         SPI_SCK,
  input  logic                         SPI_MOSI,
  input  logic                         AMP_CS,
  input  logic                         AMP_SHDN,
  output logic                         AMP_DOUT,
  output logic [CHANNELS*GAIN_W-1:0]   GAIN,
  output logic                         GAIN_VALID,
  output logic                         ERR_FRAME,
  output logic                         ERR_CODE
);

  localparam int FRAME = frame_bits(CHANNELS, GAIN_W);
  localparam int CNT_W = cnt_bits(FRAME);
  localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME + 1);
  localparam logic [GAIN_W-1:0] MAX_FIELD = GAIN_W'(MAX_CODE);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic shdn_level, shdn_rise, shdn_fall;
  logic [1:0] mosi_sync_reg;
  logic       mosi_sync;

  sync_edge u_sck (
    .clk(CLK), .rst_n(RST_N), .async_in(SPI_SCK),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge u_cs (
    .clk(CLK), .rst_n(RST_N), .async_in(AMP_CS),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge u_shdn (
    .clk(CLK), .rst_n(RST_N), .async_in(AMP_SHDN),
    .level(shdn_level), .rise(shdn_rise), .fall(shdn_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, sck_level, shdn_rise};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) mosi_sync_reg <= '0;
    else        mosi_sync_reg <= {mosi_sync_reg[0], SPI_MOSI};
  end
  assign mosi_sync = mosi_sync_reg[1];

  amp_state_e               state_reg, state_next;
  logic [FRAME-1:0]         gain_reg, gain_next;
  logic [FRAME-1:0]         sin_reg, sin_next;
  logic [FRAME-1:0]         sout_reg, sout_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic                     valid_reg, valid_next;
  logic                     errf_reg, errf_next;
  logic                     errc_reg, errc_next;
  logic [CHANNELS-1:0]      field_bad;

  // Channel 0 sits in the most significant field.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_range
      assign field_bad[gi] = sin_reg[(CHANNELS-1-gi)*GAIN_W +: GAIN_W] > MAX_FIELD;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      gain_reg  <= '0;
      sin_reg   <= '0;
      sout_reg  <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      errf_reg  <= 1'b0;
      errc_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      gain_reg  <= gain_next;
      sin_reg   <= sin_next;
      sout_reg  <= sout_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      errf_reg  <= errf_next;
      errc_reg  <= errc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gain_next  = gain_reg;
    sin_next   = sin_reg;
    sout_next  = sout_reg;
    cnt_next   = cnt_reg;
    valid_next = 1'b0;
    errf_next  = 1'b0;
    errc_next  = 1'b0;
    if (shdn_level) begin
      // Shutdown wins over everything, including a frame in flight.
      state_next = ST_SHUTDOWN;
      gain_next  = '0;
      sin_next   = '0;
      sout_next  = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_SHUTDOWN: begin
          if (shdn_fall) state_next = ST_IDLE;
        end
        ST_IDLE: begin
          if (cs_fall) begin
            sout_next  = gain_reg;
            cnt_next   = '0;
            state_next = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // A CS edge masks any SCK edge seen in the same cycle.
          if (cs_rise) begin
            state_next = ST_IDLE;
            if (cnt_reg != CNT_FRAME) begin
              errf_next = 1'b1;
            end else if (|field_bad) begin
              errc_next = 1'b1;
            end else begin
              gain_next  = sin_reg;
              valid_next = 1'b1;
            end
          end else if (sck_rise) begin
            sin_next = {sin_reg[FRAME-2:0], mosi_sync};
            if (cnt_reg != CNT_SAT) cnt_next = cnt_reg + 1'b1;
          end else if (sck_fall) begin
            sout_next = {sout_reg[FRAME-2:0], 1'b0};
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign AMP_DOUT   = cs_level ? 1'b0 : sout_reg[FRAME-1];
  assign GAIN       = gain_reg;
  assign GAIN_VALID = valid_reg;
  assign ERR_FRAME  = errf_reg;
  assign ERR_CODE   = errc_reg;

endmodule

// File: tb/tb_amp_gain_spi_slave.sv
// Drives one SPI bus into a 2-channel and a 4-channel gain slave and checks both against a frame-level model.
module tb_amp_gain_spi_slave;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N, SPI_SCK, SPI_MOSI, AMP_CS, AMP_SHDN;
  logic        dout_a, gv_a, ef_a, ec_a;
  logic        dout_b, gv_b, ef_b, ec_b;
  logic [7:0]  gain_a;
  logic [15:0] gain_b;

  amp_gain_spi_slave #(.CHANNELS(2), .GAIN_W(4), .MAX_CODE(7)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
    .AMP_CS(AMP_CS), .AMP_SHDN(AMP_SHDN), .AMP_DOUT(dout_a), .GAIN(gain_a),
    .GAIN_VALID(gv_a), .ERR_FRAME(ef_a), .ERR_CODE(ec_a)
  );
  amp_gain_spi_slave #(.CHANNELS(4), .GAIN_W(4), .MAX_CODE(15)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
    .AMP_CS(AMP_CS), .AMP_SHDN(AMP_SHDN), .AMP_DOUT(dout_b), .GAIN(gain_b),
    .GAIN_VALID(gv_b), .ERR_FRAME(ef_b), .ERR_CODE(ec_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Running pulse tallies; frames compare deltas against snapshots.
  int n_gv_a = 0, n_ef_a = 0, n_ec_a = 0;
  int n_gv_b = 0, n_ef_b = 0, n_ec_b = 0;
  int overlap = 0;
  always @(negedge CLK) begin
    if (RST_N) begin
      n_gv_a += int'(gv_a); n_ef_a += int'(ef_a); n_ec_a += int'(ec_a);
      n_gv_b += int'(gv_b); n_ef_b += int'(ef_b); n_ec_b += int'(ec_b);
      if (int'(gv_a) + int'(ef_a) + int'(ec_a) > 1) overlap++;
      if (int'(gv_b) + int'(ef_b) + int'(ec_b) > 1) overlap++;
    end
  end

  int b_gv_a, b_ef_a, b_ec_a, b_gv_b, b_ef_b, b_ec_b;
  logic [31:0] cap_a, cap_b;
  logic [31:0] exp_a, exp_b;

  task automatic snap();
    b_gv_a = n_gv_a; b_ef_a = n_ef_a; b_ec_a = n_ec_a;
    b_gv_b = n_gv_b; b_ef_b = n_ef_b; b_ec_b = n_ec_b;
  endtask

  // Pulse counts packed as valid/frame/code nibbles.
  function automatic logic [31:0] pulses_a();
    return 32'((n_gv_a - b_gv_a) * 256 + (n_ef_a - b_ef_a) * 16 + (n_ec_a - b_ec_a));
  endfunction
  function automatic logic [31:0] pulses_b();
    return 32'((n_gv_b - b_gv_b) * 256 + (n_ef_b - b_ef_b) * 16 + (n_ec_b - b_ec_b));
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic cs_low();
    snap();
    cap_a = '0;
    cap_b = '0;
    AMP_CS = 1'b0;
    wait_clk(5);
  endtask

  task automatic send_bit(input logic b);
    SPI_MOSI = b;
    wait_clk(5);
    cap_a = {cap_a[30:0], dout_a};
    cap_b = {cap_b[30:0], dout_b};
    SPI_SCK = 1'b1;
    wait_clk(5);
    SPI_SCK = 1'b0;
    wait_clk(5);
  endtask

  task automatic cs_high();
    SPI_MOSI = 1'b0;
    AMP_CS   = 1'b1;
    wait_clk(12);
  endtask

  // 0 = accepted, 1 = wrong length, 2 = code out of range
  function automatic int outcome(input int f, input int w, input int mx, input logic [31:0] d, input int n);
    if (n != f) return 1;
    for (int c = 0; c < f / w; c++)
      if (int'((d >> (w * c)) & ((32'd1 << w) - 32'd1)) > mx) return 2;
    return 0;
  endfunction

  // Old register bits MSB first, zeros once the old contents run out.
  function automatic logic [31:0] readback(input logic [31:0] g, input int f, input int n);
    return (n >= f) ? (g << (n - f)) : (g >> (f - n));
  endfunction

  function automatic logic [31:0] pulse_code(input int o);
    return (o == 0) ? 32'h100 : (o == 1) ? 32'h010 : 32'h001;
  endfunction

  task automatic frame(input string tag, input logic [31:0] data, input int n);
    logic [31:0] d;
    int oa, ob;
    d = data & ((32'd1 << n) - 32'd1);
    cs_low();
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
    cs_high();
    oa = outcome(8, 4, 7, d, n);
    ob = outcome(16, 4, 15, d, n);
    check({tag, " readback_a"}, cap_a, readback(exp_a, 8, n));
    check({tag, " readback_b"}, cap_b, readback(exp_b, 16, n));
    if (oa == 0) exp_a = d;
    if (ob == 0) exp_b = d;
    check({tag, " gain_a"}, 32'(gain_a), exp_a);
    check({tag, " gain_b"}, 32'(gain_b), exp_b);
    check({tag, " pulses_a"}, pulses_a(), pulse_code(oa));
    check({tag, " pulses_b"}, pulses_b(), pulse_code(ob));
    $display("frame %s data=%0h bits=%0d gain_a=%0h gain_b=%0h", tag, d, n, gain_a, gain_b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; SPI_SCK = 1'b0; SPI_MOSI = 1'b0; AMP_CS = 1'b1; AMP_SHDN = 1'b0;
    exp_a = '0; exp_b = '0;
    wait_clk(4);
    RST_N = 1'b1;
    snap();
    wait_clk(8);
    check("reset gain_a", 32'(gain_a), 32'h0);
    check("reset gain_b", 32'(gain_b), 32'h0);
    check("reset dout_a", 32'(dout_a), 32'h0);
    check("reset pulses_a", pulses_a(), 32'h0);
    check("reset pulses_b", pulses_b(), 32'h0);

    snap();
    AMP_SHDN = 1'b1; wait_clk(6);
    AMP_SHDN = 1'b0; wait_clk(6);
    check("shdn_pulse pulses_a", pulses_a(), 32'h0);
    $display("shdn pulse done gain_a=%0h", gain_a);

    frame("g12", 32'h12, 8);
    frame("g34", 32'h34, 8);
    frame("len7", 32'h55, 7);
    frame("len9", 32'h1AB, 9);
    frame("code18", 32'h18, 8);
    frame("g77", 32'h77, 8);

    cs_low();
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    AMP_SHDN = 1'b1;
    wait_clk(6);
    exp_a = '0; exp_b = '0;
    check("shdn_mid gain_a", 32'(gain_a), exp_a);
    AMP_SHDN = 1'b0;
    wait_clk(6);
    cs_high();
    check("shdn_mid gain_a_after", 32'(gain_a), exp_a);
    check("shdn_mid pulses_a", pulses_a(), 32'h0);
    check("shdn_mid pulses_b", pulses_b(), 32'h0);
    $display("shdn mid-frame done gain_a=%0h gain_b=%0h", gain_a, gain_b);

    frame("g1234", 32'h1234, 16);
    frame("len12", 32'h123, 12);
    frame("len0", 32'h0, 0);

    for (int k = 0; k < 20; k++) begin
      logic [31:0] d;
      int mode, n;
      mode = $urandom_range(0, 3);
      d = $urandom;
      case (mode)
        0: begin n = 8; d = 32'($urandom_range(0, 9) * 16 + $urandom_range(0, 9)); end
        1: n = 16;
        2: n = $urandom_range(0, 18);
        default: n = 8;
      endcase
      frame($sformatf("rnd%0d", k), d, n);
    end

    check("pulse overlap", 32'(overlap), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
